// File: rtl/main_memory_adc_packer.sv
// main_memory_adc_packer: packs per-clock ADC samples into BRAM_WORD_NUM-lane words for main memory writes
// Optional feature macro: ADC_PACKER_TEST_PATTERN_EN (adds i_adc_packer_test_en ramp source)
// Ports:
//   i_adc_packer_clk / i_adc_packer_reset  write clock, synchronous active-high reset
//   i_adc_packer_data / _data_valid        two's-complement sample and qualifier
//   i_adc_packer_start / _abort            capture request / cancel
//   i_adc_packer_ext_trig / _ext_trig_en   asynchronous trigger and arm enable
//   i_adc_packer_word_cnt                  packed words to capture, sampled at start
//   o_adc_packer_wr_data / _wr_clk_en      packed word and one-cycle write strobe
//   o_adc_packer_busy / _done              ARMED-or-CAPTURE / DONE status
module main_memory_adc_packer #(
    parameter int ADC_MAX_DATA_SIZE = 16,
    parameter int BRAM_WORD_NUM     = 8,
    parameter int ADC_DATA_SIZE     = 14,
    parameter int WORD_CNT_W        = 16
) (
    input  logic                                       i_adc_packer_clk,
    input  logic                                       i_adc_packer_reset,
    input  logic [ADC_DATA_SIZE-1:0]                   i_adc_packer_data,
    input  logic                                       i_adc_packer_data_valid,
    input  logic                                       i_adc_packer_start,
    input  logic                                       i_adc_packer_abort,
    input  logic                                       i_adc_packer_ext_trig,
    input  logic                                       i_adc_packer_ext_trig_en,
    input  logic [WORD_CNT_W-1:0]                      i_adc_packer_word_cnt,
`ifdef ADC_PACKER_TEST_PATTERN_EN
    input  logic                                       i_adc_packer_test_en,
`endif
    output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] o_adc_packer_wr_data,
    output logic                                       o_adc_packer_wr_clk_en,
    output logic                                       o_adc_packer_busy,
    output logic                                       o_adc_packer_done
);
    localparam int LW = BRAM_WORD_NUM > 1 ? $clog2(BRAM_WORD_NUM) : 1;
    localparam int DW = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
    logic [1:0] state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [WORD_CNT_W-1:0] word_q, word_d, cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d, wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d;
    logic [2:0] trig_q, trig_d;
    logic [ADC_MAX_DATA_SIZE-1:0] sample;
    logic accept, trig_rise, idle_like;
    // trig_q[1:0] form the synchronizer; trig_q[2] is the previous synchronized level
    assign trig_d    = {trig_q[1:0], i_adc_packer_ext_trig};
    assign trig_rise = trig_q[1] & ~trig_q[2];
    assign accept    = state_q == CAPTURE && i_adc_packer_data_valid && !i_adc_packer_abort;
    assign idle_like = state_q == IDLE || state_q == DONE;
`ifdef ADC_PACKER_TEST_PATTERN_EN
    logic [ADC_MAX_DATA_SIZE-1:0] ramp_q, ramp_d;
    assign sample = i_adc_packer_test_en ? ramp_q
                  : ADC_MAX_DATA_SIZE'($signed(i_adc_packer_data));
`else
    assign sample = ADC_MAX_DATA_SIZE'($signed(i_adc_packer_data));
`endif
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
`ifdef ADC_PACKER_TEST_PATTERN_EN
        ramp_d    = ramp_q;
`endif
        if (i_adc_packer_abort) begin
            state_d = IDLE;
        end else if (i_adc_packer_start && idle_like) begin
            cnt_d   = i_adc_packer_word_cnt;
            word_d  = '0;
            lane_d  = '0;
            state_d = i_adc_packer_word_cnt == '0 ? DONE
                    : i_adc_packer_ext_trig_en ? ARMED : CAPTURE;
`ifdef ADC_PACKER_TEST_PATTERN_EN
            ramp_d  = '0;
`endif
        end else if (state_q == ARMED && trig_rise) begin
            state_d = CAPTURE;
        end else if (accept) begin
            buf_d[lane_q*ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE] = sample;
`ifdef ADC_PACKER_TEST_PATTERN_EN
            ramp_d = ramp_q + 1'b1;
`endif
            if (lane_q == LW'(BRAM_WORD_NUM - 1)) begin
                lane_d    = '0;
                wr_data_d = buf_d;
                wr_en_d   = 1'b1;
                word_d    = word_q + 1'b1;
                state_d   = word_d == cnt_q ? DONE : CAPTURE;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end
    always_ff @(posedge i_adc_packer_clk) begin
        if (i_adc_packer_reset) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            trig_q    <= '0;
`ifdef ADC_PACKER_TEST_PATTERN_EN
            ramp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            trig_q    <= trig_d;
`ifdef ADC_PACKER_TEST_PATTERN_EN
            ramp_q    <= ramp_d;
`endif
        end
    end
    assign o_adc_packer_wr_data   = wr_data_q;
    assign o_adc_packer_wr_clk_en = wr_en_q;
    assign o_adc_packer_busy      = state_q == ARMED || state_q == CAPTURE;
    assign o_adc_packer_done      = state_q == DONE;
endmodule
